// File: rtl/sipo_deser.sv
// Serial-in parallel-out deserializer: assembles WIDTH-bit words from a qualified
// bit stream and offers them through a one-word valid/ready holding register.
module sipo_deser #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       ser_valid_i,
    input  logic                       ser_data_i,
    input  logic                       ready_i,
    input  logic                       clear_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       valid_o,
    output logic                       overrun_o,
    output logic                       abort_o,
    output logic [$clog2(WIDTH+1)-1:0] bit_cnt_o
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             capture, complete, abort_set;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ser_valid_i) state_d = SHIFT;
            SHIFT:   if (!ser_valid_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The count is always 0 in IDLE, so the same completion test serves both states.
    always_comb begin
        capture   = ser_valid_i;
        complete  = ser_valid_i && (bit_cnt_o == LAST_CNT);
        abort_set = (state_q == SHIFT) && !ser_valid_i && (bit_cnt_o != '0);
        if (MSB_FIRST) shift_d = {shift_q[WIDTH-2:0], ser_data_i};
        else           shift_d = {ser_data_i, shift_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            shift_q   <= '0;
            bit_cnt_o <= '0;
            abort_o   <= 1'b0;
        end else begin
            abort_o <= abort_set;
            if (abort_set) begin
                shift_q   <= '0;
                bit_cnt_o <= '0;
            end else if (capture) begin
                shift_q   <= shift_d;
                bit_cnt_o <= complete ? '0 : bit_cnt_o + 1'b1;
            end
        end
    end

    // A word completing while the held word is being popped replaces it without overrun.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_o    <= '0;
            valid_o   <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            if (complete && (!valid_o || ready_i)) begin
                data_o  <= shift_d;
                valid_o <= 1'b1;
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
            if (complete && valid_o && !ready_i) overrun_o <= 1'b1;
            else if (clear_i)                    overrun_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sipo_deser.sv
// Self-checking bench for sipo_deser: an MSB-first and an LSB-first instance share
// one serial stream; delivered words are matched against a scoreboard queue.
module tb_sipo_deser;

    logic       clk_i = 1'b0;
    logic       rst_n_i = 1'b1;
    logic       ser_valid_i = 1'b0;
    logic       ser_data_i = 1'b0;
    logic       ready_i = 1'b0;
    logic       clear_i = 1'b0;
    logic [3:0] data_m, data_l;
    logic       valid_m, valid_l, ovr_m, ovr_l, abort_m, abort_l;
    logic [2:0] cnt_m, cnt_l;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] q_msb[$];
    logic [3:0] q_lsb[$];

    sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .ser_valid_i(ser_valid_i), .ser_data_i(ser_data_i),
        .ready_i(ready_i), .clear_i(clear_i), .data_o(data_m), .valid_o(valid_m),
        .overrun_o(ovr_m), .abort_o(abort_m), .bit_cnt_o(cnt_m)
    );

    sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .ser_valid_i(ser_valid_i), .ser_data_i(ser_data_i),
        .ready_i(ready_i), .clear_i(clear_i), .data_o(data_l), .valid_o(valid_l),
        .overrun_o(ovr_l), .abort_o(abort_l), .bit_cnt_o(cnt_l)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [3:0] rev4(input logic [3:0] w);
        return {w[0], w[1], w[2], w[3]};
    endfunction

    // The LSB-first instance sees the same stream, so its word is the bit reversal.
    task automatic push_word(input logic [3:0] w);
        q_msb.push_back(w);
        q_lsb.push_back(rev4(w));
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ser_valid_i = 1'b1;
        ser_data_i  = b;
        tick();
    endtask

    task automatic send_word(input logic [3:0] w, input bit keep_valid);
        for (int i = 3; i >= 0; i--) send_bit(w[i]);
        if (!keep_valid) ser_valid_i = 1'b0;
    endtask

    always @(negedge clk_i) begin
        if (rst_n_i && valid_m && ready_i) begin
            checks++;
            if (q_msb.size() == 0) begin
                $display("[TB] FAIL sb_msb_unexpected: got word %h, expected none", data_m);
                errors++;
            end else begin
                logic [3:0] exp_w;
                exp_w = q_msb.pop_front();
                if (data_m !== exp_w) begin
                    $display("[TB] FAIL sb_msb_word: got %h, expected %h", data_m, exp_w);
                    errors++;
                end
            end
        end
        if (rst_n_i && valid_l && ready_i) begin
            checks++;
            if (q_lsb.size() == 0) begin
                $display("[TB] FAIL sb_lsb_unexpected: got word %h, expected none", data_l);
                errors++;
            end else begin
                logic [3:0] exp_w;
                exp_w = q_lsb.pop_front();
                if (data_l !== exp_w) begin
                    $display("[TB] FAIL sb_lsb_word: got %h, expected %h", data_l, exp_w);
                    errors++;
                end
            end
        end
    end

    task automatic check_all_zero(input string name);
        checks++;
        if ({data_m, valid_m, ovr_m, abort_m, cnt_m, data_l, valid_l, ovr_l, abort_l, cnt_l} !== '0) begin
            $display("[TB] FAIL %s: msb d=%h v=%b o=%b a=%b c=%0d lsb d=%h v=%b o=%b a=%b c=%0d, expected all 0",
                     name, data_m, valid_m, ovr_m, abort_m, cnt_m, data_l, valid_l, ovr_l, abort_l, cnt_l);
            errors++;
        end
    endtask

    task automatic test_reset();
        #2 rst_n_i = 1'b0;
        #1 check_all_zero("reset_state");
        @(negedge clk_i) rst_n_i = 1'b1;
        tick();
        check_all_zero("after_release");
    endtask

    task automatic test_msb_first();
        ready_i = 1'b1;
        push_word(4'h6);
        send_word(4'h6, 1'b0);
        checks++;
        if (valid_m !== 1'b1 || data_m !== 4'h6) begin
            $display("[TB] FAIL msb_word: v=%b d=%h, expected v=1 d=6", valid_m, data_m); errors++;
        end
        tick();
        checks++;
        if (valid_m !== 1'b0 || ovr_m !== 1'b0 || abort_m !== 1'b0) begin
            $display("[TB] FAIL msb_pulse: v=%b o=%b a=%b, expected 0 0 0", valid_m, ovr_m, abort_m); errors++;
        end
    endtask

    task automatic test_lsb_first();
        ready_i = 1'b1;
        push_word(4'h8);
        send_word(4'h8, 1'b0);
        checks++;
        if (valid_l !== 1'b1 || data_l !== 4'h1) begin
            $display("[TB] FAIL lsb_word: v=%b d=%h, expected v=1 d=1", valid_l, data_l); errors++;
        end
        tick();
    endtask

    task automatic test_overrun();
        ready_i = 1'b0;
        push_word(4'hA);
        send_word(4'hA, 1'b1);
        send_word(4'h3, 1'b0);
        checks++;
        if (ovr_m !== 1'b1 || ovr_l !== 1'b1 || valid_m !== 1'b1 || data_m !== 4'hA) begin
            $display("[TB] FAIL overrun_set: o=%b/%b v=%b d=%h, expected 1/1 1 a", ovr_m, ovr_l, valid_m, data_m);
            errors++;
        end
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        checks++;
        if (ovr_m !== 1'b0 || ovr_l !== 1'b0) begin
            $display("[TB] FAIL overrun_clear: o=%b/%b, expected 0/0", ovr_m, ovr_l); errors++;
        end
        ready_i = 1'b1;
        tick();
        checks++;
        if (valid_m !== 1'b0 || valid_l !== 1'b0) begin
            $display("[TB] FAIL pop_after_hold: v=%b/%b, expected 0/0", valid_m, valid_l); errors++;
        end
        ready_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        ready_i = 1'b0;
        push_word(4'h5);
        send_word(4'h5, 1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        ready_i = 1'b1;
        push_word(4'hC);
        send_bit(1'b0);
        ser_valid_i = 1'b0;
        checks++;
        if (data_m !== 4'hC || valid_m !== 1'b1 || ovr_m !== 1'b0 || data_l !== 4'h3) begin
            $display("[TB] FAIL pop_and_load: d=%h v=%b o=%b dl=%h, expected c 1 0 3", data_m, valid_m, ovr_m, data_l);
            errors++;
        end
        tick();
        ready_i = 1'b0;
    endtask

    task automatic test_abort();
        ready_i = 1'b0;
        send_bit(1'b1);
        send_bit(1'b0);
        checks++;
        if (cnt_m !== 3'd2) begin
            $display("[TB] FAIL mid_count: got %0d, expected 2", cnt_m); errors++;
        end
        ser_valid_i = 1'b0;
        ser_data_i  = 1'b1;
        tick();
        checks++;
        if (abort_m !== 1'b1 || abort_l !== 1'b1 || cnt_m !== 3'd0 || valid_m !== 1'b0) begin
            $display("[TB] FAIL abort_pulse: a=%b/%b c=%0d v=%b, expected 1/1 0 0", abort_m, abort_l, cnt_m, valid_m);
            errors++;
        end
        tick();
        checks++;
        if (abort_m !== 1'b0 || abort_l !== 1'b0) begin
            $display("[TB] FAIL abort_width: a=%b/%b, expected 0/0", abort_m, abort_l); errors++;
        end
        ready_i = 1'b1;
        push_word(4'h9);
        send_word(4'h9, 1'b0);
        checks++;
        if (data_m !== 4'h9 || valid_m !== 1'b1) begin
            $display("[TB] FAIL after_abort: d=%h v=%b, expected 9 1", data_m, valid_m); errors++;
        end
        tick();
    endtask

    task automatic test_async_reset();
        ready_i = 1'b1;
        send_bit(1'b1);
        send_bit(1'b1);
        ser_valid_i = 1'b1;
        ser_data_i  = 1'b1;
        #3 rst_n_i = 1'b0;
        ser_valid_i = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge clk_i) rst_n_i = 1'b1;
        tick();
        check_all_zero("reset_no_flags");
        push_word(4'hF);
        send_word(4'hF, 1'b0);
        checks++;
        if (data_m !== 4'hF || valid_m !== 1'b1 || data_l !== 4'hF) begin
            $display("[TB] FAIL post_reset_word: d=%h/%h v=%b, expected f/f 1", data_m, data_l, valid_m); errors++;
        end
        tick();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_overrun();
        test_back_to_back();
        test_abort();
        test_async_reset();
        repeat (2) tick();
        checks++;
        if (q_msb.size() != 0 || q_lsb.size() != 0) begin
            $display("[TB] FAIL sb_drain: %0d/%0d words undelivered, expected 0/0", q_msb.size(), q_lsb.size());
            errors++;
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sipo_deser.md
Name: sipo_deser

Overview:
Serial-in parallel-out deserializer that sits directly downstream of the 4-bit PISO serializer. It samples the serial bit stream while the serializer's busy output is high and assembles WIDTH-bit words. Each completed word is presented on a valid/ready parallel interface through a one-word holding register. The block flags overrun when a new word completes while the held word is unconsumed, and flags abort when a word ends short.

Parameters:
WIDTH, 4, word width in bits; legal range 2..32.
MSB_FIRST, 1, 1 = first serial bit is data_o[WIDTH-1]; 0 = first bit is data_o[0].

Ports:
clk_i  input  1  clock, all state updates on rising edge.
rst_n_i  input  1  asynchronous active-low reset; assertion is asynchronous, release is synchronous to clk_i.
ser_valid_i  input  1  serial bit qualifier; connects to the serializer's busy_o.
ser_data_i  input  1  serial data bit; connects to the serializer's data_o.
ready_i  input  1  consumer accepts data_o when ready_i and valid_o are both high.
clear_i  input  1  synchronous clear of the overrun_o sticky flag.
data_o  output  WIDTH  assembled word; stable while valid_o is high.
valid_o  output  1  holding register contains an unconsumed word.
overrun_o  output  1  sticky; a completed word was dropped.
abort_o  output  1  1-cycle pulse; ser_valid_i fell mid-word.
bit_cnt_o  output  $clog2(WIDTH+1)  bits captured in the current word, for debug.

Behaviour:
- Reset (async, any cycle): FSM goes to IDLE. Shift register, bit_cnt_o, data_o, valid_o, overrun_o and abort_o all go to 0. A word in progress or held is discarded.
- FSM states are IDLE and SHIFT.
  - IDLE -> SHIFT on a cycle with ser_valid_i=1. The bit on that edge is captured and bit_cnt_o becomes 1.
  - In SHIFT, each edge with ser_valid_i=1 captures ser_data_i and increments bit_cnt_o.
  - The capture that brings the count to WIDTH completes the word. bit_cnt_o returns to 0 and the state stays SHIFT if ser_valid_i is still high; otherwise the next edge returns to IDLE with no abort.
  - SHIFT with ser_valid_i=0 and 0 < bit_cnt_o < WIDTH: return to IDLE, discard the partial word, clear the count, and pulse abort_o high for exactly the next cycle.
- Bit ordering:
  - MSB_FIRST=1: shift left, new bit enters at bit 0.
  - MSB_FIRST=0: shift right, new bit enters at bit WIDTH-1.
- Word completion latency: valid_o rises on the clock edge that samples the last bit. data_o is visible in the cycle after that edge.
- Handshake:
  - valid_o stays high and data_o stays stable until a cycle with ready_i=1.
  - valid_o falls on that edge unless a new word completes on the same edge.
  - valid_o never depends combinationally on ready_i.
- Simultaneous completion and pop (valid_o=1, ready_i=1, word completes): the new word loads, valid_o stays 1, and there is no overrun.
- Completion while full (valid_o=1, ready_i=0): the new word is dropped and data_o is unchanged. overrun_o is set on the same edge and stays high until clear_i or reset.
- clear_i and a new overrun on the same edge: overrun_o = 1 (set wins).
- Back-to-back words (ser_valid_i held high across 2*WIDTH cycles) are supported with no gap cycle.
- ser_data_i is ignored when ser_valid_i=0.
- Reset mid-word or mid-hold: the word is lost silently. abort_o and overrun_o are not asserted after reset release.

Test Plan:
1. Reset, then the serializer loads 4'h6 and the bench holds ready_i=1 -> serial stream 0,1,1,0 (MSB first); valid_o pulses 1 cycle after the 4th bit with data_o=4'h6; overrun_o=0, abort_o=0.
2. MSB_FIRST=0 build, stream bits 1,0,0,0 in that order -> data_o=4'h1.
3. Two words 4'hA then 4'h3 back-to-back with ready_i=0 throughout -> data_o=4'hA held; overrun_o=1 after the 8th bit. Assert clear_i -> overrun_o=0. Then ready_i=1 -> valid_o falls.
4. Word 4'h5 held with ready_i=0; the 4th bit of the next word 4'hC completes on the same edge ready_i=1 -> data_o=4'hC, valid_o stays 1, overrun_o=0.
5. Drop ser_valid_i after 2 bits -> abort_o high for exactly 1 cycle, bit_cnt_o=0, valid_o unchanged. The next full word 4'h9 is received correctly.
6. Assert rst_n_i low asynchronously mid-clock during bit 3 -> all outputs 0 immediately. After release, word 4'hF is received correctly with no stale bits.
